// File: rtl/stage_flight_kinematics_pkg.sv
// Shared constants for the stage flight kinematics core.
// Contents:
//   UM_PER_MM        mm/s^2 -> um/s^2 scale applied to g0
//   BANG_90          90 degrees in binary-angle units
//   Q_SHIFT          fraction bits of the trig tables (unsigned Q2.15)
//   COS_LUT/SIN_LUT  17-entry tables, 5.625 degree steps from 0 to 90 degrees
//   burn_state_e     burn sequencer states
package stage_flight_pkg;

    localparam logic [63:0] UM_PER_MM = 64'd1000;
    localparam logic [63:0] BANG_90   = 64'd65536;
    localparam int          Q_SHIFT   = 15;
    localparam int          LUT_N     = 17;

    localparam logic [16:0] COS_LUT [LUT_N] = '{
        17'd32768, 17'd32610, 17'd32138, 17'd31357, 17'd30274, 17'd28899,
        17'd27246, 17'd25330, 17'd23170, 17'd20788, 17'd18205, 17'd15447,
        17'd12540, 17'd9512,  17'd6393,  17'd3212,  17'd0
    };

    localparam logic [16:0] SIN_LUT [LUT_N] = '{
        17'd0,     17'd3212,  17'd6393,  17'd9512,  17'd12540, 17'd15447,
        17'd18205, 17'd20788, 17'd23170, 17'd25330, 17'd27246, 17'd28899,
        17'd30274, 17'd31357, 17'd32138, 17'd32610, 17'd32768
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MDOT,
        ST_RUN,
        ST_DV
    } burn_state_e;

endpackage

// File: rtl/stage_flight_kinematics_if.sv
// Signal bundle between the stage sequencer / height integrator and the
// kinematics core.
//   master: drives stage constants, stage_load, backward and height
//   slave : the kinematics core; drives velocity, mass, tick, gimbal and
//           trajectory outputs
interface stage_flight_kinematics_if #(
    parameter int N = 64
);
    logic         stage_load;
    logic         backward;
    logic [N-1:0] specific_impulse;
    logic [N-1:0] initial_weight;
    logic [N-1:0] propellant_weight;
    logic [N-1:0] burntime;
    logic [N-1:0] height;
    logic [N-1:0] velocity;
    logic [N-1:0] after_weight;
    logic         ignition_end;
    logic         sec_tick;
    logic         gimbal_enable;
    logic [N-1:0] angular_velocity;
    logic [N-1:0] noair_altitude;
    logic [N-1:0] noair_distance;
    logic [N-1:0] altitude;
    logic [N-1:0] distance;

    modport master (
        output stage_load, backward, specific_impulse, initial_weight,
               propellant_weight, burntime, height,
        input  velocity, after_weight, ignition_end, sec_tick, gimbal_enable,
               angular_velocity, noair_altitude, noair_distance, altitude, distance
    );

    modport slave (
        input  stage_load, backward, specific_impulse, initial_weight,
               propellant_weight, burntime, height,
        output velocity, after_weight, ignition_end, sec_tick, gimbal_enable,
               angular_velocity, noair_altitude, noair_distance, altitude, distance
    );
endinterface

// File: rtl/stage_flight_kinematics_seq_divider_64.sv
// 64-bit unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, resetb  clock, asynchronous active-low reset
//   start_i      load operands and (re)start; overrides a division in flight
//   dividend_i   numerator
//   divisor_i    denominator; zero yields an all-ones quotient
//   busy_o       division in progress
//   done_o       1-cycle pulse, quotient_o valid from this cycle on
//   quotient_o   floor(dividend / divisor)
module seq_divider_64 (
    input  logic        clk,
    input  logic        resetb,
    input  logic        start_i,
    input  logic [63:0] dividend_i,
    input  logic [63:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] quotient_o
);
    logic [63:0] rem_q;
    logic [63:0] quo_q;
    logic [63:0] dsr_q;
    logic [5:0]  cnt_q;
    logic        busy_q;
    logic        done_q;

    logic [64:0] rem_sh;
    logic        ge;
    logic [63:0] rem_d;

    // With a zero divisor every trial subtraction succeeds, so the quotient
    // fills with ones without any special case.
    always_comb begin
        rem_sh = {rem_q, quo_q[63]};
        ge     = (rem_sh >= {1'b0, dsr_q});
        rem_d  = ge ? 64'(rem_sh - {1'b0, dsr_q}) : rem_sh[63:0];
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= '0;
            quo_q  <= dividend_i;
            dsr_q  <= divisor_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= {quo_q[62:0], ge};
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd63) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;
endmodule

// File: rtl/stage_flight_kinematics.sv
// Per-stage flight kinematics: rocket-equation velocity integration in 1 s
// Euler steps, sticky gimbal activation at a fixed altitude, and post-gimbal
// altitude/downrange accumulation from a pitch angle ramp.
// Ports:
//   clk, resetb  clock, asynchronous active-low reset
//   bus          stage_flight_kinematics_if.slave (stage constants, height in;
//                velocity, mass, sec_tick, ignition_end, gimbal and
//                trajectory outputs)
module stage_flight_kinematics
    import stage_flight_pkg::*;
#(
    parameter int           N             = 64,
    parameter logic [N-1:0] GRAVITY       = N'(9799),
    parameter int           TICKS_PER_SEC = 50000,
    parameter logic [N-1:0] ALT_THRESH    = N'(64'd30_000_000_000),
    parameter logic [N-1:0] PITCH_RATE    = N'(512)
) (
    input logic                      clk,
    input logic                      resetb,
    stage_flight_kinematics_if.slave bus
);
    localparam logic [31:0] TICK_LAST = 32'(TICKS_PER_SEC - 1);

    function automatic logic [N-1:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[N] ? '1 : s[N-1:0];
    endfunction

    function automatic logic [N-1:0] sat_sub(input logic [N-1:0] a, input logic [N-1:0] b);
        return (a >= b) ? a - b : '0;
    endfunction

    // Second tick generator
    logic [31:0] tick_cnt_q;
    logic        tick_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_q     <= (tick_cnt_q == TICK_LAST);
            tick_cnt_q <= (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 32'd1;
        end
    end

    // Burn sequencer
    burn_state_e  state_q, state_d;
    logic [N-1:0] isp_q, isp_d, burn_q, burn_d, mdot_q, mdot_d;
    logic [N-1:0] mass_q, mass_d, elapsed_q, elapsed_d, vel_q, vel_d;
    logic         pend_q, pend_d, ign_q, ign_d;

    logic         div_start, div_busy, div_done;
    logic [63:0]  div_dividend, div_divisor, div_quot;
    logic [N-1:0] dv_num;

    assign dv_num = GRAVITY * isp_q * mdot_q * UM_PER_MM;

    seq_divider_64 u_div (
        .clk       (clk),
        .resetb    (resetb),
        .start_i   (div_start),
        .dividend_i(div_dividend),
        .divisor_i (div_divisor),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quotient_o(div_quot)
    );

    always_comb begin
        state_d      = state_q;
        isp_d        = isp_q;
        burn_d       = burn_q;
        mdot_d       = mdot_q;
        mass_d       = mass_q;
        elapsed_d    = elapsed_q;
        vel_d        = vel_q;
        // A tick seen while a division is outstanding is remembered, not lost.
        pend_d       = pend_q | (tick_q && (state_q != ST_IDLE));
        ign_d        = 1'b0;
        div_start    = 1'b0;
        div_dividend = dv_num;
        div_divisor  = mass_q;

        if (bus.stage_load) begin
            // Velocity deliberately kept: it carries from stage to stage.
            isp_d        = bus.specific_impulse;
            burn_d       = bus.burntime;
            mass_d       = bus.initial_weight;
            elapsed_d    = '0;
            pend_d       = 1'b0;
            div_start    = 1'b1;
            div_dividend = bus.propellant_weight;
            div_divisor  = bus.burntime;
            state_d      = ST_MDOT;
        end else begin
            unique case (state_q)
                ST_MDOT: begin
                    if (div_done) begin
                        mdot_d  = div_quot;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if ((pend_q || tick_q) && !div_busy) begin
                        div_start = 1'b1;
                        pend_d    = 1'b0;
                        state_d   = ST_DV;
                    end
                end
                ST_DV: begin
                    // dv was divided by the pre-step mass; mass drops afterwards.
                    if (div_done) begin
                        vel_d     = bus.backward ? sat_sub(vel_q, div_quot) : sat_add(vel_q, div_quot);
                        mass_d    = mass_q - mdot_q;
                        elapsed_d = elapsed_q + N'(1);
                        if (elapsed_q + N'(1) >= burn_q) begin
                            ign_d   = 1'b1;
                            pend_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: pend_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= ST_IDLE;
            isp_q     <= '0;
            burn_q    <= '0;
            mdot_q    <= '0;
            mass_q    <= '0;
            elapsed_q <= '0;
            vel_q     <= '0;
            pend_q    <= 1'b0;
            ign_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            isp_q     <= isp_d;
            burn_q    <= burn_d;
            mdot_q    <= mdot_d;
            mass_q    <= mass_d;
            elapsed_q <= elapsed_d;
            vel_q     <= vel_d;
            pend_q    <= pend_d;
            ign_q     <= ign_d;
        end
    end

    // Gimbal and trajectory accumulation
    logic         gimbal_q;
    logic [N-1:0] noair_alt_q, alt_q, dist_q;
    logic [16:0]  theta_q;
    logic [4:0]   lut_idx;
    logic [80:0]  prod_cos, prod_sin;
    logic [N-1:0] theta_sum;

    // The step uses the angle before this tick's increment.
    always_comb begin
        lut_idx   = theta_q[16:12];
        prod_cos  = 81'(vel_q) * 81'(COS_LUT[lut_idx]);
        prod_sin  = 81'(vel_q) * 81'(SIN_LUT[lut_idx]);
        theta_sum = N'(theta_q) + PITCH_RATE;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            gimbal_q    <= 1'b0;
            noair_alt_q <= '0;
            alt_q       <= '0;
            dist_q      <= '0;
            theta_q     <= '0;
        end else begin
            if (!gimbal_q && (bus.height >= ALT_THRESH)) begin
                gimbal_q    <= 1'b1;
                noair_alt_q <= bus.height;
            end
            if (tick_q && gimbal_q) begin
                alt_q   <= alt_q + N'(prod_cos >> Q_SHIFT);
                dist_q  <= dist_q + N'(prod_sin >> Q_SHIFT);
                theta_q <= (theta_sum > BANG_90) ? 17'(BANG_90) : 17'(theta_sum);
            end
        end
    end

    assign bus.velocity         = vel_q;
    assign bus.after_weight     = mass_q;
    assign bus.ignition_end     = ign_q;
    assign bus.sec_tick         = tick_q;
    assign bus.gimbal_enable    = gimbal_q;
    assign bus.angular_velocity = gimbal_q ? PITCH_RATE : '0;
    assign bus.noair_altitude   = noair_alt_q;
    assign bus.noair_distance   = '0;
    assign bus.altitude         = alt_q;
    assign bus.distance         = dist_q;
endmodule

// File: tb/tb_stage_flight_kinematics.sv
// Directed bench for stage_flight_kinematics: two instances share clock and
// reset (A: default pitch rate, B: pitch rate 4096), both at 100 ticks/s.
module tb_stage_flight_kinematics;
    logic clk    = 1'b0;
    logic resetb = 1'b1;
    always #5 clk = ~clk;

    stage_flight_kinematics_if #(.N(64)) ifa ();
    stage_flight_kinematics_if #(.N(64)) ifb ();

    stage_flight_kinematics #(.N(64), .TICKS_PER_SEC(100)) dut_a (
        .clk(clk), .resetb(resetb), .bus(ifa)
    );
    stage_flight_kinematics #(.N(64), .TICKS_PER_SEC(100), .PITCH_RATE(64'd4096)) dut_b (
        .clk(clk), .resetb(resetb), .bus(ifb)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int ign_a    = 0;
    int ign_b    = 0;

    localparam logic [63:0] COS_T [17] = '{
        64'd32768, 64'd32610, 64'd32138, 64'd31357, 64'd30274, 64'd28899,
        64'd27246, 64'd25330, 64'd23170, 64'd20788, 64'd18205, 64'd15447,
        64'd12540, 64'd9512,  64'd6393,  64'd3212,  64'd0
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (ifa.ignition_end === 1'b1) ign_a++;
        if (ifb.ignition_end === 1'b1) ign_b++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        cyc();
        while (ifa.sec_tick !== 1'b1 && n < 150) begin
            cyc();
            n++;
        end
        chk("tick_wait", {63'd0, ifa.sec_tick}, 64'd1);
    endtask

    task automatic pulse_load(input bit la, input bit lb);
        ifa.stage_load = la;
        ifb.stage_load = lb;
        cyc();
        ifa.stage_load = 1'b0;
        ifb.stage_load = 1'b0;
    endtask

    task automatic set_a(input logic [63:0] isp, m0, prop, bt);
        ifa.specific_impulse  = isp;
        ifa.initial_weight    = m0;
        ifa.propellant_weight = prop;
        ifa.burntime          = bt;
    endtask

    logic [63:0] vel_exp [1:5];
    logic [63:0] aw_exp  [1:5];
    logic [63:0] alt_m, dist_m;
    int          idx;

    initial begin
        vel_exp[1] = 64'd293_970_000;   aw_exp[1] = 64'd900;
        vel_exp[2] = 64'd620_603_333;   aw_exp[2] = 64'd800;
        vel_exp[3] = 64'd988_065_833;   aw_exp[3] = 64'd700;
        vel_exp[4] = 64'd1_408_022_975; aw_exp[4] = 64'd600;
        vel_exp[5] = 64'd1_897_972_975; aw_exp[5] = 64'd500;

        ifa.stage_load = 0; ifa.backward = 0; ifa.height = 0;
        ifb.stage_load = 0; ifb.backward = 0; ifb.height = 0;
        set_a(0, 0, 0, 0);
        ifb.specific_impulse = 0; ifb.initial_weight = 0;
        ifb.propellant_weight = 0; ifb.burntime = 0;

        // Reset state
        #3 resetb = 1'b0;
        cycles(3);
        chk("rst_velocity", ifa.velocity, 64'd0);
        chk("rst_after_weight", ifa.after_weight, 64'd0);
        chk("rst_sec_tick", {63'd0, ifa.sec_tick}, 64'd0);
        chk("rst_ign_end", {63'd0, ifa.ignition_end}, 64'd0);
        chk("rst_gimbal", {63'd0, ifa.gimbal_enable}, 64'd0);
        chk("rst_angvel", ifa.angular_velocity, 64'd0);
        chk("rst_altitude", ifa.altitude, 64'd0);
        chk("rst_distance", ifa.distance, 64'd0);
        resetb = 1'b1;

        // Scenario 1 on A, plus a 1 s burn on B giving exactly 1_000_000 um/s
        wait_tick();
        set_a(64'd300, 64'd1000, 64'd500, 64'd5);
        ifb.specific_impulse = 64'd1000; ifb.initial_weight = 64'd9799;
        ifb.propellant_weight = 64'd1;   ifb.burntime = 64'd1;
        pulse_load(1'b1, 1'b1);
        chk("load_after_weight", ifa.after_weight, 64'd1000);
        for (int k = 1; k <= 5; k++) begin
            wait_tick();
            cycles(80);
            chk($sformatf("burn_vel_t%0d", k), ifa.velocity, vel_exp[k]);
            chk($sformatf("burn_aw_t%0d", k), ifa.after_weight, aw_exp[k]);
            chk($sformatf("burn_ign_t%0d", k), 64'(ign_a), (k == 5) ? 64'd1 : 64'd0);
            if (k == 1) begin
                chk("b_vel", ifb.velocity, 64'd1_000_000);
                chk("b_after_weight", ifb.after_weight, 64'd9798);
                chk("b_ign", 64'(ign_b), 64'd1);
            end
        end
        wait_tick();
        cycles(80);
        chk("post_burn_vel", ifa.velocity, 64'd1_897_972_975);
        chk("post_burn_aw", ifa.after_weight, 64'd500);
        chk("post_burn_ign", 64'(ign_a), 64'd1);

        // Scenario 3: gimbal threshold on A
        ifa.height = 64'd29_999_999_999;
        cycles(3);
        chk("gim_below", {63'd0, ifa.gimbal_enable}, 64'd0);
        chk("gim_below_angvel", ifa.angular_velocity, 64'd0);
        ifa.height = 64'd30_000_000_000;
        cyc();
        chk("gim_on", {63'd0, ifa.gimbal_enable}, 64'd1);
        chk("gim_noair_alt", ifa.noair_altitude, 64'd30_000_000_000);
        chk("gim_angvel", ifa.angular_velocity, 64'd512);
        ifa.height = 64'd1;
        cycles(5);
        chk("gim_sticky", {63'd0, ifa.gimbal_enable}, 64'd1);
        chk("gim_noair_hold", ifa.noair_altitude, 64'd30_000_000_000);
        chk("gim_noair_dist", ifa.noair_distance, 64'd0);

        // Scenario 4: trajectory on B, velocity fixed at 1_000_000
        wait_tick();
        ifb.height = 64'd30_000_000_000;
        cyc();
        chk("traj_gim_on", {63'd0, ifb.gimbal_enable}, 64'd1);
        chk("traj_alt0", ifb.altitude, 64'd0);
        alt_m = 64'd0;
        dist_m = 64'd0;
        for (int t = 0; t < 18; t++) begin
            wait_tick();
            cyc();
            idx = (t < 16) ? t : 16;
            alt_m  = alt_m  + ((64'd1_000_000 * COS_T[idx]) >> 15);
            dist_m = dist_m + ((64'd1_000_000 * COS_T[16 - idx]) >> 15);
            chk($sformatf("traj_alt_t%0d", t + 1), ifb.altitude, alt_m);
            chk($sformatf("traj_dist_t%0d", t + 1), ifb.distance, dist_m);
        end
        chk("traj_vel_held", ifb.velocity, 64'd1_000_000);

        // Scenario 5: velocity carry-over, then async reset at tick 3
        wait_tick();
        pulse_load(1'b1, 1'b0);
        wait_tick();
        cycles(80);
        chk("carry_vel_t1", ifa.velocity, 64'd2_191_942_975);
        wait_tick();
        cycles(80);
        chk("carry_vel_t2", ifa.velocity, 64'd2_518_576_308);
        wait_tick();
        resetb = 1'b0;
        #1;
        chk("arst_velocity", ifa.velocity, 64'd0);
        chk("arst_after_weight", ifa.after_weight, 64'd0);
        chk("arst_sec_tick", {63'd0, ifa.sec_tick}, 64'd0);
        chk("arst_gimbal", {63'd0, ifa.gimbal_enable}, 64'd0);
        chk("arst_noair_alt", ifa.noair_altitude, 64'd0);
        chk("arst_angvel", ifa.angular_velocity, 64'd0);
        chk("arst_b_altitude", ifb.altitude, 64'd0);
        chk("arst_b_velocity", ifb.velocity, 64'd0);
        cycles(2);
        resetb = 1'b1;

        // Clean restart after reset: dv = 1000 * Isp = 100_000_000
        wait_tick();
        set_a(64'd100_000, 64'd9799, 64'd1, 64'd1);
        ign_a = 0;
        pulse_load(1'b1, 1'b0);
        wait_tick();
        cycles(80);
        chk("restart_vel", ifa.velocity, 64'd100_000_000);
        chk("restart_aw", ifa.after_weight, 64'd9798);
        chk("restart_ign", 64'(ign_a), 64'd1);

        // Scenario 6: mid-burn reload with zero propellant, one second burn
        wait_tick();
        set_a(64'd300, 64'd1000, 64'd500, 64'd5);
        pulse_load(1'b1, 1'b0);
        wait_tick();
        cycles(80);
        chk("s6_vel_t1", ifa.velocity, 64'd393_970_000);
        chk("s6_aw_t1", ifa.after_weight, 64'd900);
        wait_tick();
        set_a(64'd300, 64'd1000, 64'd0, 64'd1);
        ign_a = 0;
        pulse_load(1'b1, 1'b0);
        cycles(70);
        chk("s6_vel_reload", ifa.velocity, 64'd393_970_000);
        chk("s6_aw_reload", ifa.after_weight, 64'd1000);
        chk("s6_ign_none", 64'(ign_a), 64'd0);
        wait_tick();
        cycles(80);
        chk("s6_vel_end", ifa.velocity, 64'd393_970_000);
        chk("s6_aw_end", ifa.after_weight, 64'd1000);
        chk("s6_ign", 64'(ign_a), 64'd1);

        // Scenario 2: retro burn, exact subtraction then floor at zero
        wait_tick();
        ifa.backward = 1'b1;
        set_a(64'd300, 64'd1000, 64'd500, 64'd5);
        pulse_load(1'b1, 1'b0);
        wait_tick();
        cycles(80);
        chk("retro_vel_t1", ifa.velocity, 64'd100_000_000);
        chk("retro_aw_t1", ifa.after_weight, 64'd900);
        wait_tick();
        cycles(80);
        chk("retro_vel_sat", ifa.velocity, 64'd0);
        chk("retro_aw_t2", ifa.after_weight, 64'd800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/stage_flight_kinematics.md
Name: stage_flight_kinematics

Overview:
- Per-stage rocket flight kinematics core. Combines three functions:
  - thrust-phase velocity integration (rocket equation, Euler form, 1 s steps);
  - gimbal (pitch-over) activation at a fixed altitude;
  - post-gimbal altitude/downrange accumulation.
- Sits between the stage-sequencer (supplies per-stage constants) and the external height integrator (supplies height).
- All quantities are unsigned 64-bit integers.
- Units: mass kg; time s; gravity mm/s²; velocity µm/s; height/altitude/distance µm; angle in binary units (90° = 65536).

Parameters:
- N, 64, datapath width.
- GRAVITY, 9799, g0 in mm/s².
- TICKS_PER_SEC, 50000, clk cycles per simulated second; minimum 80.
- ALT_THRESH, 30_000_000_000, gimbal activation height in µm (30 km).
- PITCH_RATE, 512, pitch increment per second, binary-angle units.

Ports:
- clk  in  1  clock
- resetb  in  1  asynchronous active-low reset
- stage_load  in  1  1-cycle pulse: latch stage constants, restart burn
- backward  in  1  1: velocity increments are subtracted (retro burn), floor 0
- specific_impulse  in  N  Isp, s
- initial_weight  in  N  stage start mass, kg
- propellant_weight  in  N  propellant mass, kg
- burntime  in  N  burn duration, s (≥1)
- height  in  N  vertical height from external integrator, µm
- velocity  out  N  current speed, µm/s
- after_weight  out  N  current mass, kg
- ignition_end  out  1  1-cycle pulse at burn completion
- sec_tick  out  1  1-cycle pulse every TICKS_PER_SEC cycles
- gimbal_enable  out  1  sticky, 1 once height ≥ ALT_THRESH
- angular_velocity  out  N  PITCH_RATE when gimbal_enable, else 0
- noair_altitude  out  N  height captured at gimbal activation
- noair_distance  out  N  downrange at activation (always 0, vertical ascent)
- altitude  out  N  altitude gained since activation, µm
- distance  out  N  downrange since activation, µm

Behaviour:
- Reset: all outputs, counters, angle and accumulators are 0; burning = 0.
- sec_tick:
  - Free-running counter 0..TICKS_PER_SEC-1.
  - Pulses when the counter wraps.
  - Counter clears on reset only.
- stage_load:
  - Latches constants.
  - mdot = propellant_weight / burntime (integer floor, iterative divider).
  - after_weight = initial_weight; elapsed = 0; burning = 1.
  - velocity is NOT cleared, so velocity carries across stages.
  - stage_load mid-burn restarts the burn with the new constants.
- Burn step, on each sec_tick while burning and not dividing:
  - dv = (GRAVITY·Isp·mdot·1000) / after_weight, floor; the old mass is the divisor.
  - velocity ± dv.
  - Subtraction saturates at 0.
  - Then after_weight -= mdot and elapsed += 1.
  - When elapsed reaches burntime: ignition_end pulses 1 cycle, burning = 0.
  - Division is a shared 64-cycle restoring divider; a result lands before the next tick.
  - A sec_tick arriving while the divider is busy is held pending, not dropped.
  - Divide-by-zero gives quotient all-ones; velocity saturates at 2^64-1.
- Gimbal:
  - Compare each cycle.
  - The first cycle with height ≥ ALT_THRESH sets gimbal_enable on the next edge and captures noair_altitude = height.
  - Sticky until reset; stage_load does not clear it.
- Pitch angle θ:
  - Starts at 0.
  - += angular_velocity on each sec_tick while gimbal_enable.
  - Saturates at 65536.
- Altitude/distance step, on each sec_tick while gimbal_enable, using θ before the update:
  - i = θ[16:12], range 0..16.
  - altitude += (velocity·COS_LUT[i]) >> 15.
  - distance += (velocity·SIN_LUT[i]) >> 15.
  - Intermediate products are 81 bits wide.
- LUT format:
  - 17 entries, unsigned Q2.15.
  - COS_LUT[0] = 32768, SIN_LUT[0] = 0.
  - COS_LUT[16] = 0, SIN_LUT[16] = 32768.
  - Entries are round(32768·cos/sin(i·90°/16)).
- Simultaneous sec_tick on the activation cycle: the altitude step starts on the next tick.

Decomposition:
- Package stage_flight_pkg holds:
  - unit constants (UM_PER_MM = 1000);
  - BANG_90 = 65536;
  - COS_LUT/SIN_LUT constant arrays;
  - the Q-format shift (15).
- One sub-module: seq_divider_64 (start/busy/done, quotient, div-by-zero → all-ones).
  - Shared by the mdot computation and the dv computation.

Test Plan:
1. Burn: TICKS_PER_SEC=100, Isp=300, m0=1000, prop=500, burn=5, stage_load → mdot=100.
   - Tick1: velocity=293_970_000, after_weight=900.
   - Tick2: velocity=620_603_333.
   - After tick5: after_weight=500, ignition_end single pulse, no further change.
2. backward=1 from velocity=100_000_000 with dv=293_970_000 → velocity=0 (saturation).
3. Gimbal: height=29_999_999_999 → gimbal_enable=0, angular_velocity=0. Then height=30_000_000_000 → next edge gimbal_enable=1, noair_altitude=30_000_000_000, angular_velocity=512. Then height drops → stays 1.
4. Trajectory: gimbal on, velocity held 1_000_000, PITCH_RATE=4096.
   - First tick: altitude=1_000_000, distance=0, θ=4096.
   - After 16 ticks: θ=65536 (saturated); later ticks add only to distance (+1_000_000 each).
5. Reset mid-burn (resetb low at tick 3 of scenario 1) → all outputs 0 immediately (asynchronous). A new stage_load after release restarts cleanly.
6. stage_load while burning with burn=1, prop=0 → mdot=0, velocity unchanged, ignition_end after 1 tick.
